// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation codes,
// FSM states and the default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mdu_abs.sv
// Sign/magnitude split of a W-bit value; neg_o is the plain two's complement
// negation so the same block also serves the sign fix-up of the result.
module mdu_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] value_i,
  input  logic         signed_i,
  output logic         sign_o,
  output logic [W-1:0] mag_o,
  output logic [W-1:0] neg_o
);

  assign neg_o  = ~value_i + W'(1);
  assign sign_o = signed_i & value_i[W-1];
  assign mag_o  = sign_o ? neg_o : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide on operand magnitudes with a final sign fix-up.
// hi/lo are architectural and only change on the completion edge.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic               accept, div_zero_req;
  logic [WIDTH-1:0]   abs_a_in, abs_b_in;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b, neg_a, neg_b;
  logic [WIDTH:0]     mul_sum, div_cand, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   mul_hi_fix;

  // Operands feed the abs blocks at accept; the accumulator halves feed them in FIX.
  always_comb begin
    abs_a_in = a_i;
    abs_b_in = b_i;
    if (state_q == S_FIX) begin
      abs_a_in = acc_q[WIDTH-1:0];
      abs_b_in = acc_q[2*WIDTH-1:WIDTH];
    end
  end

  mdu_abs #(.W(WIDTH)) u_abs_a (
    .value_i  (abs_a_in),
    .signed_i (op_i[0]),
    .sign_o   (sign_a),
    .mag_o    (mag_a),
    .neg_o    (neg_a)
  );

  mdu_abs #(.W(WIDTH)) u_abs_b (
    .value_i  (abs_b_in),
    .signed_i (op_i[0]),
    .sign_o   (sign_b),
    .mag_o    (mag_b),
    .neg_o    (neg_b)
  );

  assign accept       = (state_q == S_IDLE) && start_i && !done_q;
  assign div_zero_req = op_i[1] && (b_i == '0);

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: remainder < divisor, so the W+1-bit difference sign is exact.
  assign div_cand = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_cand - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH]
                  ? {div_cand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Upper half of a 2W negation only takes the +1 carry when the low half is zero.
  assign mul_hi_fix = (acc_q[WIDTH-1:0] == '0) ? neg_b : ~acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = div_zero_req ? S_FIX : S_RUN;
      S_RUN:  if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q != S_IDLE);
    done_o        = done_q;
    hi_o          = hi_q;
    lo_o          = lo_q;
    div_by_zero_o = dbz_q;
  end

  always_comb begin
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = op_i;
          sa_d       = sign_a;
          sb_d       = sign_b;
          dbz_pend_d = div_zero_req;
          dbz_d      = 1'b0;
          cnt_d      = CW'(WIDTH);
          if (div_zero_req) begin
            acc_d  = {a_i, {WIDTH{1'b1}}};
            opnd_d = '0;
          end else if (op_i[1]) begin
            acc_d  = {{WIDTH{1'b0}}, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag_b};
            opnd_d = mag_a;
          end
        end
      end
      S_RUN: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        if (!dbz_pend_q) begin
          if (op_q[1]) begin
            if (sa_q ^ sb_q) acc_d[WIDTH-1:0] = neg_a;
            if (sa_q) acc_d[2*WIDTH-1:WIDTH] = neg_b;
          end else if (sa_q ^ sb_q) begin
            acc_d = {mul_hi_fix, neg_a};
          end
        end
      end
      S_DONE: begin
        hi_d   = acc_q[2*WIDTH-1:WIDTH];
        lo_d   = acc_q[WIDTH-1:0];
        dbz_d  = dbz_pend_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      op_q       <= OP_MULU;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// reset/overlap sequences and random operations against an arithmetic model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  a_i, b_i;
  logic          busy_o, done_o, div_by_zero_o;
  logic [W-1:0]  hi_o, lo_o;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .op_i          (op_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Arithmetic reference: full-width products and C-style truncating division.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    int     sa, sb, q, r;
    longint p;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    sa = $signed(a);
    sb = $signed(b);
    if (op[1] && b == '0) begin
      hi = a;
      lo = '1;
      dz = 1'b1;
    end else if (op == 2'b00) begin
      p = longint'(a) * longint'(b);
      {hi, lo} = p[31:0];
    end else if (op == 2'b01) begin
      p = longint'(sa) * longint'(sb);
      {hi, lo} = p[31:0];
    end else if (op == 2'b10) begin
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
      lo = q[15:0];
      hi = r[15:0];
    end else begin
      q = sa / sb;
      r = sa % sb;
      lo = q[15:0];
      hi = r[15:0];
    end
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_i = op;
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk("accept_busy", 32'(busy_o), 32'(1));
    chk("dbz_cleared_on_accept", 32'(div_by_zero_o), 32'(0));
  endtask

  task automatic finish_op(input logic [1:0] op, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic ed, input int lat, input bit noise, input bit tail);
    int n = 0;
    bit seen = 0, stable = 1, busy_ok = 1;
    while (!seen && n < 40) begin
      @(posedge clk_i);
      #1;
      n++;
      if (noise && n == 3) begin
        start_i = 1'b1;
        op_i = ~op;
        a_i = W'($urandom);
        b_i = W'($urandom);
      end
      if (noise && n == 5) start_i = 1'b0;
      if (done_o) seen = 1;
      else begin
        if (hi_o !== prev_hi || lo_o !== prev_lo) stable = 0;
        if (!busy_o) busy_ok = 0;
      end
    end
    chk("done_seen", 32'(seen), 32'(1));
    chk("latency", 32'(n), 32'(lat));
    chk("hi", 32'(hi_o), 32'(eh));
    chk("lo", 32'(lo_o), 32'(el));
    chk("div_by_zero", 32'(div_by_zero_o), 32'(ed));
    chk("busy_at_done", 32'(busy_o), 32'(0));
    chk("hold_prev_result", 32'(stable), 32'(1));
    chk("busy_during_op", 32'(busy_ok), 32'(1));
    prev_hi = eh;
    prev_lo = el;
    if (tail) begin
      @(posedge clk_i);
      #1;
      chk("done_one_cycle", 32'(done_o), 32'(0));
      chk("no_queued_start", 32'(busy_o), 32'(0));
    end
  endtask

  initial begin
    logic [W-1:0] eh, el, ra, rb;
    logic [1:0]   rop;
    logic         ed;
    bit           no_done;

    vecs[0]  = '{2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 18};
    vecs[1]  = '{2'b01, 16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 1'b0, 18};
    vecs[2]  = '{2'b01, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 18};
    vecs[3]  = '{2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 18};
    vecs[4]  = '{2'b10, 16'h1234, 16'h0010, 16'h0004, 16'h0123, 1'b0, 18};
    vecs[5]  = '{2'b10, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 2};
    vecs[6]  = '{2'b00, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 1'b0, 18};
    vecs[7]  = '{2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 18};
    vecs[8]  = '{2'b11, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0, 18};
    vecs[9]  = '{2'b11, 16'h8000, 16'h0000, 16'h8000, 16'hFFFF, 1'b1, 2};
    vecs[10] = '{2'b00, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 18};
    vecs[11] = '{2'b10, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 18};

    rst_i = 1'b1;
    start_i = 1'b0;
    op_i = '0;
    a_i = '0;
    b_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_busy", 32'(busy_o), 32'(0));
    chk("reset_done", 32'(done_o), 32'(0));
    chk("reset_hi", 32'(hi_o), 32'(0));
    chk("reset_lo", 32'(lo_o), 32'(0));
    chk("reset_dbz", 32'(div_by_zero_o), 32'(0));
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      finish_op(vecs[i].op, vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat, 1'b0, 1'b1);
    end

    // Reset while iteration 8 is in flight.
    issue(2'b00, 16'hFFFF, 16'hFFFF);
    repeat (7) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst_busy", 32'(busy_o), 32'(0));
    chk("midrst_hi", 32'(hi_o), 32'(0));
    chk("midrst_lo", 32'(lo_o), 32'(0));
    chk("midrst_done", 32'(done_o), 32'(0));
    rst_i = 1'b0;
    prev_hi = '0;
    prev_lo = '0;
    no_done = 1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk_i);
      #1;
      if (done_o || busy_o) no_done = 0;
    end
    chk("midrst_no_done", 32'(no_done), 32'(1));
    issue(2'b00, 16'h0003, 16'h0005);
    finish_op(2'b00, 16'h0000, 16'h000F, 1'b0, 18, 1'b0, 1'b1);

    // start pulsed mid-operation with different operands must be dropped.
    issue(2'b11, 16'hFFF9, 16'h0002);
    finish_op(2'b11, 16'hFFFF, 16'hFFFD, 1'b0, 18, 1'b1, 1'b1);

    // start held across done: ignored while done=1, taken the cycle done drops.
    issue(2'b01, 16'hFFFD, 16'h0007);
    finish_op(2'b01, 16'hFFFF, 16'hFFEB, 1'b0, 18, 1'b0, 1'b0);
    op_i = 2'b10;
    a_i = 16'h1234;
    b_i = 16'h0010;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("start_during_done_ignored", 32'(busy_o), 32'(0));
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk("accept_after_done_drop", 32'(busy_o), 32'(1));
    finish_op(2'b10, 16'h0004, 16'h0123, 1'b0, 18, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 16'h8000; rb = 16'hFFFF; end
        2: rb = W'($urandom_range(1, 3));
        default: ;
      endcase
      model(rop, ra, rb, eh, el, ed);
      issue(rop, ra, rb);
      finish_op(rop, eh, el, ed, ed ? 2 : W + 2, (i % 5 == 0) && !ed, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
